// File: rtl/alu_arbiter.sv
// Purpose : two-requester front end for one shared ALU; grants one op, latches its operands, returns the result.
// Latency : ready seen in cycle k -> rsp_valid from cycle k+2; one op per 3 cycles at best (IDLE, EXEC, RESP).
// Backpr. : response held stable in RESP until rsp_ready; no new grant while busy. Macro ALU_ARB_RR_EN selects round-robin.
module alu_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  // requester 0
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [5:0]  req0_op,
  input  logic [5:0]  req0_func,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  // requester 1
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [5:0]  req1_op,
  input  logic [5:0]  req1_func,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  // shared ALU
  output logic [31:0] alu_input1,
  output logic [31:0] alu_input2,
  output logic [5:0]  alu_op,
  output logic [5:0]  alu_func,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_wr_file,
  // response
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_wr,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic        gnt_fire;   // a grant happens at the coming edge
  logic        gnt_id;     // which requester wins when gnt_fire is high

  logic [5:0]  op_q;
  logic [5:0]  func_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        id_q;

  // A grant can only be made from IDLE and needs at least one requester.
  assign gnt_fire = (state_q == S_IDLE) && (req0_valid || req1_valid);

`ifdef ALU_ARB_RR_EN
  // Last-granted requester; reset value 1 lets req0 win the first tie.
  logic rr_ptr_q;

  // Round-robin pick: on a tie, serve whoever was not granted last.
  always_comb begin
    gnt_id = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt_id = ~rr_ptr_q;
    end else begin
      gnt_id = ~req0_valid;
    end
  end

  // Remember the winner of every grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= 1'b1;
    end else if (gnt_fire) begin
      rr_ptr_q <= gnt_id;
    end
  end
`else
  // Fixed priority: req0 wins whenever it is valid.
  always_comb begin
    gnt_id = ~req0_valid;
  end
`endif

  // Ready is purely combinational so the requester sees acceptance in the same cycle.
  assign req0_ready = gnt_fire && !gnt_id;
  assign req1_ready = gnt_fire &&  gnt_id;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: grant -> EXEC, EXEC always lasts one cycle, RESP waits for the consumer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_fire) begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Operand registers load only on a grant, so the ALU inputs never glitch with requester traffic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      func_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
      id_q   <= 1'b0;
    end else if (gnt_fire) begin
      op_q   <= gnt_id ? req1_op   : req0_op;
      func_q <= gnt_id ? req1_func : req0_func;
      a_q    <= gnt_id ? req1_a    : req0_a;
      b_q    <= gnt_id ? req1_b    : req0_b;
      id_q   <= gnt_id;
    end
  end

  assign alu_input1 = a_q;
  assign alu_input2 = b_q;
  assign alu_op     = op_q;
  assign alu_func   = func_q;

  // Capture the ALU outputs on the EXEC-to-RESP edge and hold them through any backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_wr     <= 1'b0;
      rsp_id     <= 1'b0;
    end else if (state_q == S_EXEC) begin
      rsp_result <= alu_result;
      rsp_zero   <= alu_zero;
      rsp_wr     <= alu_wr_file;
      rsp_id     <= id_q;
    end
  end

  assign rsp_valid = (state_q == S_RESP);
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Purpose : directed bench for alu_arbiter with an ALU stub and an expected-response queue.
// Latency : checks ready-to-rsp_valid distance of 2 cycles and grant spacing of 3 cycles.
// Backpr. : holds rsp_ready low in RESP for 10 cycles and checks the response stays frozen.
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready;
  logic [5:0]  req0_op, req0_func;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready;
  logic [5:0]  req1_op, req1_func;
  logic [31:0] req1_a, req1_b;
  logic [31:0] alu_input1, alu_input2;
  logic [5:0]  alu_op, alu_func;
  logic [31:0] alu_result;
  logic        alu_zero, alu_wr_file;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_wr, busy;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_func(req0_func),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_func(req1_func),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_input1(alu_input1), .alu_input2(alu_input2), .alu_op(alu_op), .alu_func(alu_func),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_wr_file(alu_wr_file),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_wr(rsp_wr), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Small reference ALU: R-type add/sub/and/or write back; opcode 100011 subtracts without write-back.
  function automatic logic [33:0] alu_model(input logic [5:0] op, input logic [5:0] func,
                                            input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        wr;
    r  = '0;
    wr = 1'b0;
    if (op == 6'b000000) begin
      wr = 1'b1;
      case (func)
        6'b100000: r = a + b;
        6'b100010: r = a - b;
        6'b100100: r = a & b;
        6'b100101: r = a | b;
        default:   r = '0;
      endcase
    end else if (op == 6'b100011) begin
      r = a - b;
    end
    return {wr, (r == 32'd0), r};
  endfunction

  // The stub ALU is combinational on whatever the arbiter drives.
  always_comb begin
    {alu_wr_file, alu_zero, alu_result} = alu_model(alu_op, alu_func, alu_input1, alu_input2);
  end

  typedef struct {
    logic        id;
    logic [31:0] result;
    logic        zero;
    logic        wr;
    int          gcyc;
  } exp_t;

  exp_t sb[$];
  int   gnt_ids[$];
  int   gnt_cycs[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic last_gnt;
  logic last_gnt_id;
  logic rsp_vld_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic id, input logic [5:0] op, input logic [5:0] func,
                          input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.id = id;
    {e.wr, e.zero, e.result} = alu_model(op, func, a, b);
    e.gcyc = cyc;
    sb.push_back(e);
    gnt_ids.push_back(int'(id));
    gnt_cycs.push_back(cyc);
    last_gnt    = 1'b1;
    last_gnt_id = id;
  endtask

  // Called at a falling edge after inputs are driven: samples the cycle, then moves to the next falling edge.
  task automatic step();
    exp_t e;
    #1;
    last_gnt = 1'b0;
    chk("one_ready_max", {31'd0, req0_ready & req1_ready}, 32'd0);
    if (rsp_valid && !rsp_vld_prev) begin
      chk("rsp_expected", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) chk("rsp_latency", cyc - sb[0].gcyc, 32'd2);
    end
    if (rsp_valid && rsp_ready && sb.size() != 0) begin
      e = sb.pop_front();
      chk("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
      chk("rsp_result", rsp_result, e.result);
      chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, e.zero});
      chk("rsp_wr", {31'd0, rsp_wr}, {31'd0, e.wr});
    end
    if (req0_ready) push_exp(1'b0, req0_op, req0_func, req0_a, req0_b);
    if (req1_ready) push_exp(1'b1, req1_op, req1_func, req1_a, req1_b);
    rsp_vld_prev = rsp_valid;
    cyc++;
    @(negedge clk);
  endtask

  task automatic wait_grant(input string tag);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (last_gnt) begin
        got = 1'b1;
        break;
      end
    end
    chk(tag, {31'd0, got}, 32'd1);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      step();
    end
    chk(tag, sb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 0; req0_op = 0; req0_func = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = 0; req1_func = 0; req1_a = 0; req1_b = 0;
    last_gnt = 0; last_gnt_id = 0;

    // Reset state
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_alu_input1", alu_input1, 32'd0);
    chk("rst_alu_op", {26'd0, alu_op}, 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);

    // Single op on req0; the first edge after reset release must grant
    @(negedge clk);
    rst_n = 1'b1;
    req0_valid = 1; req0_op = 6'b000000; req0_func = 6'b100000; req0_a = 32'd5; req0_b = 32'd7;
    step();
    chk("first_grant", {31'd0, last_gnt}, 32'd1);
    chk("first_grant_id", {31'd0, last_gnt_id}, 32'd0);
    req0_valid = 0;
    chk("exec_busy", {31'd0, busy}, 32'd1);
    chk("exec_alu_input1", alu_input1, 32'd5);
    chk("exec_alu_input2", alu_input2, 32'd7);
    chk("exec_alu_op", {26'd0, alu_op}, 32'd0);
    chk("exec_alu_func", {26'd0, alu_func}, 32'h20);
    chk("exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    wait_drain("single_drain");
    chk("single_result_const", rsp_result, 32'd12);
    chk("single_idle", {31'd0, busy}, 32'd0);

    // Zero flag via req1
    req1_valid = 1; req1_op = 6'b100011; req1_func = 6'b000000; req1_a = 32'd9; req1_b = 32'd9;
    wait_grant("zero_grant");
    chk("zero_grant_id", {31'd0, last_gnt_id}, 32'd1);
    req1_valid = 0;
    wait_drain("zero_drain");
    chk("zero_flag_const", {31'd0, rsp_zero}, 32'd1);

    // Backpressure: 10 cycles of rsp_ready low with req1 waiting
    rsp_ready = 0;
    req0_valid = 1; req0_op = 6'b000000; req0_func = 6'b100010; req0_a = 32'd20; req0_b = 32'd3;
    wait_grant("bp_grant");
    req0_valid = 0;
    req1_valid = 1; req1_op = 6'b000000; req1_func = 6'b100101; req1_a = 32'hF0; req1_b = 32'h0F;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid) break;
      step();
    end
    chk("bp_rsp_valid_seen", {31'd0, rsp_valid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_busy", {31'd0, busy}, 32'd1);
      chk("bp_req0_ready", {31'd0, req0_ready}, 32'd0);
      chk("bp_req1_ready", {31'd0, req1_ready}, 32'd0);
      chk("bp_result_stable", rsp_result, 32'd17);
      chk("bp_id_stable", {31'd0, rsp_id}, 32'd0);
      step();
    end
    rsp_ready = 1;
    chk("bp_hs_req1_ready", {31'd0, req1_ready}, 32'd0);
    step();
    chk("bp_after_hs_busy", {31'd0, busy}, 32'd0);
    chk("bp_after_hs_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    step();
    chk("bp_next_grant", {31'd0, last_gnt}, 32'd1);
    chk("bp_next_grant_id", {31'd0, last_gnt_id}, 32'd1);
    req1_valid = 0;
    wait_drain("bp_drain");

    // Reset while in EXEC discards the op
    req0_valid = 1; req0_op = 6'b000000; req0_func = 6'b100000; req0_a = 32'd1; req0_b = 32'd2;
    wait_grant("rst_exec_grant");
    req0_valid = 0;
    rst_n = 0;
    #1;
    chk("rst_exec_busy", {31'd0, busy}, 32'd0);
    chk("rst_exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_exec_alu_input1", alu_input1, 32'd0);
    chk("rst_exec_alu_input2", alu_input2, 32'd0);
    chk("rst_exec_alu_func", {26'd0, alu_func}, 32'd0);
    chk("rst_exec_rsp_result", rsp_result, 32'd0);
    sb.delete();
    rsp_vld_prev = 1'b0;
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rst_exec_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end

    // Contention: both valid continuously
    req0_valid = 1; req0_op = 6'b000000; req0_func = 6'b100000; req0_a = 32'd100; req0_b = 32'd1;
    req1_valid = 1; req1_op = 6'b100011; req1_func = 6'b000000; req1_a = 32'd50;  req1_b = 32'd8;
    gnt_ids.delete();
    gnt_cycs.delete();
    for (int i = 0; i < 12; i++) step();
    req0_valid = 0;
    req1_valid = 0;
    chk("cont_grant_count", gnt_ids.size(), 32'd4);
    for (int i = 0; i < gnt_ids.size() && i < 4; i++) begin
`ifdef ALU_ARB_RR_EN
      chk("cont_grant_id", gnt_ids[i], i % 2);
`else
      chk("cont_grant_id", gnt_ids[i], 32'd0);
`endif
      if (i > 0) chk("cont_grant_spacing", gnt_cycs[i] - gnt_cycs[i-1], 32'd3);
    end
    wait_drain("cont_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
